serial_loader: RTL

SERIAL_LOADER -- requirements
Module: serial_loader

---
 rtl/serial_loader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/serial_loader.sv
// serial_loader: assembles a WIDTH-bit word from a serial line, then checks one even-parity bit.
// Latency: start sampled at edge E0 -> load strobe during the cycle after edge E(WIDTH+1).
// Backpressure: none; start is ignored mid-frame and honoured only in IDLE or LOAD (back-to-back).
module serial_loader #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             load_o,
    output logic             busy_o,
    output logic             perr_o
);

    // Counter holds 0..WIDTH data bits, so it never wraps inside a frame.
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        LOAD   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             load_q, load_d;
    logic             busy_q, busy_d;
    logic             perr_q, perr_d;
    logic [WIDTH-1:0] sr_shifted;

    // Where a new serial bit enters depends on the transmit bit order.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign sr_shifted = {sr_q[WIDTH-2:0], sin_i};
        end else begin : g_lsb_first
            assign sr_shifted = {sin_i, sr_q[WIDTH-1:1]};
        end
    endgenerate

    // Next-state logic; load/busy are derived from the next state so they leave as flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        dout_d  = dout_q;
        perr_d  = perr_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    perr_d  = 1'b0;
                end
            end
            SHIFT: begin
                sr_d  = sr_shifted;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                // Even parity: data bits XOR parity bit must be zero.
                if ((^sr_q) == sin_i) begin
                    state_d = LOAD;
                    dout_d  = sr_q;
                end else begin
                    state_d = IDLE;
                    perr_d  = 1'b1;
                end
            end
            LOAD: begin
                if (start_i) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    perr_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        load_d = (state_d == LOAD);
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset takes effect without waiting for the clock.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            dout_q  <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            dout_q  <= dout_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            perr_q  <= perr_d;
        end
    end

    assign dout_o = dout_q;
    assign load_o = load_q;
    assign busy_o = busy_q;
    assign perr_o = perr_q;

endmodule
